// File: rtl/sr_bank_driver.sv
// sr_bank_driver: drives a bank of SR flip-flops with load/clear/preset commands and verifies the bank by readback.
// Optional macro SRDRV_READBACK_EN adds the CHECK state and the err/err_mask readback.
`default_nettype none

module sr_bank_driver #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] ff_s,
  output logic [WIDTH-1:0] ff_r,
  output logic             ff_preset,
  output logic             ff_clr,
  input  logic [WIDTH-1:0] ff_q,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask
);

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_PRESET = 2'b10;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] expected, expected_nxt;
  logic [WIDTH-1:0] s_nxt, r_nxt;
  logic             clr_nxt, preset_nxt, done_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             transfer;

  assign cmd_ready = clr_n & (state == IDLE);
  assign transfer  = cmd_valid & cmd_ready;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state     <= IDLE;
      expected  <= '0;
      cnt       <= '0;
      ff_s      <= '0;
      ff_r      <= '0;
      ff_clr    <= 1'b0;
      ff_preset <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      expected  <= expected_nxt;
      cnt       <= cnt_nxt;
      ff_s      <= s_nxt;
      ff_r      <= r_nxt;
      ff_clr    <= clr_nxt;
      ff_preset <= preset_nxt;
      done      <= done_nxt;
    end
  end

  // Drive values are computed only on the transfer edge, so they are high for the DRIVE cycle alone.
  always_comb begin
    state_nxt    = state;
    expected_nxt = expected;
    s_nxt        = '0;
    r_nxt        = '0;
    clr_nxt      = 1'b0;
    preset_nxt   = 1'b0;
    done_nxt     = 1'b0;
    cnt_nxt      = cnt;
    case (state)
      IDLE: begin
        if (transfer) begin
          state_nxt = DRIVE;
          case (cmd_op)
            OP_LOAD: begin
              expected_nxt = cmd_data;
              s_nxt        = cmd_data & ~ff_q;
              r_nxt        = ~cmd_data & ff_q;
            end
            OP_CLEAR: begin
              expected_nxt = '0;
              clr_nxt      = 1'b1;
            end
            OP_PRESET: begin
              expected_nxt = '1;
              preset_nxt   = 1'b1;
            end
            default: expected_nxt = ff_q;
          endcase
        end
      end
      DRIVE: begin
        state_nxt = SETTLE;
        cnt_nxt   = '0;
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
`ifdef SRDRV_READBACK_EN
          state_nxt = CHECK;
`else
          state_nxt = IDLE;
          done_nxt  = 1'b1;
`endif
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
`ifdef SRDRV_READBACK_EN
      CHECK: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SRDRV_READBACK_EN
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      err      <= 1'b0;
      err_mask <= '0;
    end else if (state == CHECK) begin
      err      <= |(ff_q ^ expected);
      err_mask <= ff_q ^ expected;
    end else begin
      err      <= 1'b0;
    end
  end
`else
  assign err      = 1'b0;
  assign err_mask = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sr_bank_driver.sv
// tb_sr_bank_driver: directed scoreboard bench for sr_bank_driver with a behavioural SR bank model.
`default_nettype none

module tb_sr_bank_driver;

  localparam int W  = 8;
  localparam int SC = 1;
`ifdef SRDRV_READBACK_EN
  localparam int LAT = 3 + SC;
  localparam bit RB  = 1'b1;
`else
  localparam int LAT = 2 + SC;
  localparam bit RB  = 1'b0;
`endif

  localparam logic [1:0] LOAD = 2'b00, CLR = 2'b01, PRE = 2'b10, NOP = 2'b11;

  logic         clk = 1'b0;
  logic         clr_n, cmd_valid, cmd_ready, ff_preset, ff_clr, done, err;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data, ff_s, ff_r, ff_q, err_mask;

  logic [W-1:0] bank, stuck0, force_val;
  logic         force_en;

  typedef struct {
    logic [W-1:0] word;
    logic         e;
    logic [W-1:0] mask;
  } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0, cyc = 0, t0 = 0, last_done = -1, d1 = 0;

  sr_bank_driver #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .clr_n(clr_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .ff_s(ff_s), .ff_r(ff_r),
    .ff_preset(ff_preset), .ff_clr(ff_clr), .ff_q(ff_q), .done(done),
    .err(err), .err_mask(err_mask)
  );

  always #5 clk = ~clk;

  // Bank model: clear dominates preset, then per-bit set/reset; stuck0 models bits that read back as 0.
  always @(posedge clk) begin
    if (force_en)       bank <= force_val;
    else if (ff_clr)    bank <= '0;
    else if (ff_preset) bank <= '1;
    else                bank <= (bank & ~ff_r) | ff_s;
  end
  assign ff_q = bank & ~stuck0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    chk("s_and_r_exclusive", ff_s & ff_r, 8'h00);
    chk("clr_preset_exclusive", 8'(ff_clr & ff_preset), 8'h00);
    if (done) begin
      last_done = cyc;
      if (sb.size() == 0) begin
        chk("spurious_done", 8'(done), 8'h00);
      end else begin
        e = sb.pop_front();
        chk("done_bank", bank, e.word);
        chk("done_err", 8'(err), 8'(e.e));
        chk("done_err_mask", err_mask, e.mask);
      end
    end else begin
      chk("err_idle", 8'(err), 8'h00);
    end
  endtask

  task automatic set_bank(input logic [W-1:0] v);
    force_en  = 1'b1;
    force_val = v;
    tick();
    force_en  = 1'b0;
  endtask

  // Offers a command, waits (bounded) for acceptance, returns in the DRIVE cycle.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] data, input bit push,
                       input logic [W-1:0] word, input logic e, input logic [W-1:0] mask,
                       input bit hold);
    int n = 0;
    exp_t x;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    chk("accept_timeout", 8'(cmd_ready), 8'h01);
    if (push) begin
      x.word = word; x.e = e; x.mask = mask;
      sb.push_back(x);
    end
    t0 = cyc;
    tick();
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (last_done <= t0 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 8'(last_done - t0), 8'(LAT));
  endtask

  initial begin
    clr_n = 1'b0; cmd_valid = 1'b0; cmd_op = NOP; cmd_data = '0;
    stuck0 = '0; force_en = 1'b1; force_val = '0;
    tick(); tick();
    chk("rst_drive", ff_s | ff_r, 8'h00);
    chk("rst_ctl", {4'b0, ff_clr, ff_preset, done, err}, 8'h00);
    chk("rst_mask", err_mask, 8'h00);
    chk("rst_ready", 8'(cmd_ready), 8'h00);
    force_en = 1'b0;
    clr_n = 1'b1;
    tick();
    chk("ready_after_rst", 8'(cmd_ready), 8'h01);

    // Load 0xA5 from 0x00
    issue(LOAD, 8'hA5, 1, 8'hA5, 1'b0, 8'h00, 0);
    chk("a5_s", ff_s, 8'hA5);
    chk("a5_r", ff_r, 8'h00);
    chk("a5_ready_busy", 8'(cmd_ready), 8'h00);
    tick();
    chk("a5_s_one_cycle", ff_s, 8'h00);
    wait_done("a5_latency");

    // Load 0x0F over 0xF0: every bit flips
    set_bank(8'hF0);
    issue(LOAD, 8'h0F, 1, 8'h0F, 1'b0, 8'h00, 0);
    chk("0f_s", ff_s, 8'h0F);
    chk("0f_r", ff_r, 8'hF0);
    tick();
    chk("0f_r_one_cycle", ff_r, 8'h00);
    wait_done("0f_latency");

    // Clear then preset
    issue(CLR, 8'h5A, 1, 8'h00, 1'b0, 8'h00, 0);
    chk("clr_ctl", {ff_s | ff_r | 8'h00} | {6'b0, ff_clr, ff_preset}, 8'h02);
    tick();
    chk("clr_one_cycle", 8'(ff_clr), 8'h00);
    wait_done("clr_latency");
    issue(PRE, 8'h5A, 1, 8'hFF, 1'b0, 8'h00, 0);
    chk("pre_ctl", (ff_s | ff_r) | {6'b0, ff_clr, ff_preset}, 8'h01);
    tick();
    chk("pre_one_cycle", 8'(ff_preset), 8'h00);
    wait_done("pre_latency");

    // Nop: no drive, bank unchanged and matches itself
    issue(NOP, 8'h12, 1, 8'hFF, 1'b0, 8'h00, 0);
    chk("nop_drive", (ff_s | ff_r) | {6'b0, ff_clr, ff_preset}, 8'h00);
    wait_done("nop_latency");

    // Bit 3 stuck at 0 on readback
    set_bank(8'h00);
    stuck0 = 8'h08;
    issue(LOAD, 8'hFF, 1, 8'hFF, RB, RB ? 8'h08 : 8'h00, 0);
    chk("stuck_s", ff_s, 8'hFF);
    wait_done("stuck_latency");
    tick();
    chk("mask_hold", err_mask, RB ? 8'h08 : 8'h00);
    stuck0 = '0;

    // Reset during DRIVE aborts the command
    set_bank(8'h00);
    issue(LOAD, 8'h55, 0, 8'h00, 1'b0, 8'h00, 0);
    chk("abort_pre_s", ff_s, 8'h55);
    clr_n = 1'b0;
    tick();
    chk("abort_drive", (ff_s | ff_r) | {6'b0, ff_clr, ff_preset}, 8'h00);
    chk("abort_ready_low", 8'(cmd_ready), 8'h00);
    clr_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++) tick();
    chk("abort_ready", 8'(cmd_ready), 8'h01);
    issue(LOAD, 8'h33, 1, 8'h33, 1'b0, 8'h00, 0);
    chk("post_abort_s", ff_s, 8'h22);
    chk("post_abort_r", ff_r, 8'h44);
    wait_done("post_abort_latency");

    // Back-to-back with cmd_valid held
    issue(LOAD, 8'h3C, 1, 8'h3C, 1'b0, 8'h00, 1);
    d1 = t0;
    issue(LOAD, 8'hC3, 1, 8'hC3, 1'b0, 8'h00, 0);
    chk("b2b_accept_gap", 8'(t0 - d1), 8'(LAT));
    d1 = last_done;
    wait_done("b2b_latency");
    chk("b2b_done_gap", 8'(last_done - d1), 8'(LAT));
    for (int i = 0; i < 3; i++) tick();
    chk("sb_drained", 8'(sb.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sr_bank_driver.md
SR_BANK_DRIVER -- requirements
Module: sr_bank_driver

Interface
REQ-001 Parameter: WIDTH, default 8, number of SR flip-flops in the driven bank.
REQ-002 Parameter: SETTLE_CYCLES, default 1, range 1-15; idle cycles between drive and readback.
REQ-003 Port: clk  input  1  rising-edge clock; sole clock.
REQ-004 Port: clr_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 Port: cmd_valid  input  1  command offered.
REQ-006 Port: cmd_ready  output  1  block accepts a command this cycle.
REQ-007 Port: cmd_op  input  2  00 load, 01 clear-all, 10 preset-all, 11 nop.
REQ-008 Port: cmd_data  input  WIDTH  target word for load; ignored otherwise.
REQ-009 Port: ff_s  output  WIDTH  per-bit S to bank.
REQ-010 Port: ff_r  output  WIDTH  per-bit R to bank.
REQ-011 Port: ff_preset  output  1  bank preset.
REQ-012 Port: ff_clr  output  1  bank clear.
REQ-013 Port: ff_q  input  WIDTH  bank Q readback.
REQ-014 Port: done  output  1  one-cycle completion pulse.
REQ-015 Port: err  output  1  readback mismatch, valid with done.
REQ-016 Port: err_mask  output  WIDTH  per-bit mismatch, held until next done.

Function
REQ-017 States IDLE, DRIVE, SETTLE, CHECK; transfer = cmd_valid & cmd_ready at a rising edge; cmd_ready = 1 only in IDLE.
REQ-018 On transfer: capture expected word (load: cmd_data; clear: 0; preset: all-ones; nop: current ff_q), go to DRIVE.
REQ-019 Load excitation, registered at transfer edge: ff_s = cmd_data & ~ff_q, ff_r = ~cmd_data & ff_q; bits already matching get S=R=0.
REQ-020 Clear: ff_clr = 1, ff_s = ff_r = 0; preset: ff_preset = 1, ff_s = ff_r = 0; nop: all drive outputs 0.
REQ-021 Drive outputs asserted for exactly the one DRIVE cycle, 0 in every other state.
REQ-022 ff_s & ff_r = 0 in every cycle; ff_clr and ff_preset never both 1.
REQ-023 SETTLE lasts SETTLE_CYCLES cycles, then CHECK for one cycle.
REQ-024 In CHECK: err_mask <= ff_q ^ expected, err <= |(ff_q ^ expected), done <= 1; next state IDLE.
REQ-025 Latency: done high in cycle 3+SETTLE_CYCLES after transfer edge; cmd_ready high in that same cycle (back-to-back allowed).
REQ-026 err and done are 0 outside the done cycle; err_mask retains last value.

Reset
REQ-027 clr_n low at a rising edge: state IDLE; ff_s, ff_r, ff_preset, ff_clr, done, err, err_mask all 0; cmd_ready 0 while clr_n low, 1 first cycle after release.
REQ-028 Reset mid-operation aborts the command: drive outputs 0 at that edge, no done pulse for the aborted command.

Configuration
REQ-029 Macro SRDRV_READBACK_EN defined: CHECK state and readback per REQ-024 present.
REQ-030 Macro SRDRV_READBACK_EN undefined: CHECK state omitted, done high in cycle 2+SETTLE_CYCLES after transfer, err and err_mask constant 0, ff_q unused.

Verification (WIDTH=8, SETTLE_CYCLES=1, SRDRV_READBACK_EN defined, behavioural SR bank model unless stated)
REQ-031 Reset, bank=0x00, load 0xA5 -> cycle 1: ff_s=0xA5, ff_r=0x00; cycle 4: done=1, err=0, err_mask=0x00, bank=0xA5.
REQ-032 Bank=0xF0, load 0x0F -> ff_s=0x0F, ff_r=0xF0 one cycle; bank=0x0F; err=0.
REQ-033 Clear then preset -> ff_clr=1 one cycle, bank 0x00, err=0; ff_preset=1 one cycle, bank 0xFF, err=0; ff_s=ff_r=0 throughout.
REQ-034 Model bit 3 stuck at 0, load 0xFF from 0x00 -> done cycle 4: err=1, err_mask=0x08.
REQ-035 clr_n low during DRIVE cycle -> all drive outputs 0 at that edge, no done, cmd_ready=1 after release; next load completes normally.
REQ-036 cmd_valid held with load 0x3C then load 0xC3 -> second transfer in first done cycle, done pulses 4 cycles apart, bank 0xC3; assertion ff_s & ff_r == 0 every cycle.
